// File: rtl/minmax_pkg.sv
// Shared definitions for the min/max scan reducer family: mode encoding,
// FSM state type and the candidate qualification rule.
package minmax_pkg;

    localparam logic MODE_MAX = 1'b0;
    localparam logic MODE_MIN = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    // A candidate takes part in the reduction only when active and not flagged.
    function automatic logic qualifies(input logic act, input logic sign);
        return act & ~sign;
    endfunction

endpackage

// File: rtl/minmax_compare.sv
// Generalised pairwise comparator: decides whether a candidate replaces the
// running best. Purely combinational so it can be reused in a tree variant.
module minmax_compare
    import minmax_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic signed [WIDTH-1:0] candidate,
    input  logic                    candidate_qualified,
    input  logic signed [WIDTH-1:0] best,
    input  logic                    found,
    input  logic                    mode,
    output logic                    take,
    output logic                    qualified_any
);

    logic better_s;

    // Strict signed comparison so that ties keep the earlier (lower) index.
    always_comb begin
        better_s = 1'b0;
        if (mode == MODE_MAX) begin
            better_s = (candidate > best);
        end else begin
            better_s = (candidate < best);
        end
    end

    // First qualifying candidate always wins; later ones only when strictly better.
    always_comb begin
        take          = 1'b0;
        qualified_any = found | candidate_qualified;
        if (candidate_qualified) begin
            take = ~found | better_s;
        end else begin
            take = 1'b0;
        end
    end

endmodule

// File: rtl/minmax_scan_reducer.sv
// Sequential min/max reducer: latches a vector of signed candidates on start,
// scans one element per clock and reports the winning value and its index.
module minmax_scan_reducer
    import minmax_pkg::*;
#(
    parameter  int WIDTH      = 8,
    parameter  int NUM_INPUTS = 8,
    localparam int IDX_W      = $clog2(NUM_INPUTS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          mode,
    input  logic [NUM_INPUTS*WIDTH-1:0]   numbers,
    input  logic [NUM_INPUTS-1:0]         activations,
    input  logic [NUM_INPUTS-1:0]         signs,
    output logic                          busy,
    output logic                          done,
    output logic signed [WIDTH-1:0]       result,
    output logic [IDX_W-1:0]              result_index,
    output logic                          result_activation
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);

    state_e                   state_q, state_d;
    logic signed [WIDTH-1:0]  nums_q [NUM_INPUTS];
    logic signed [WIDTH-1:0]  nums_d [NUM_INPUTS];
    logic [NUM_INPUTS-1:0]    act_q, act_d;
    logic [NUM_INPUTS-1:0]    sign_q, sign_d;
    logic                     mode_q, mode_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic signed [WIDTH-1:0]  best_q, best_d;
    logic [IDX_W-1:0]         best_idx_q, best_idx_d;
    logic                     found_q, found_d;

    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic signed [WIDTH-1:0]  result_q, result_d;
    logic [IDX_W-1:0]         result_index_q, result_index_d;
    logic                     result_activation_q, result_activation_d;

    logic signed [WIDTH-1:0]  cand_s;
    logic                     cand_qual_s;
    logic                     take_s;
    logic                     qual_any_s;

    assign cand_s      = nums_q[idx_q];
    assign cand_qual_s = qualifies(act_q[idx_q], sign_q[idx_q]);

    minmax_compare #(
        .WIDTH (WIDTH)
    ) u_compare (
        .candidate           (cand_s),
        .candidate_qualified (cand_qual_s),
        .best                (best_q),
        .found               (found_q),
        .mode                (mode_q),
        .take                (take_s),
        .qualified_any       (qual_any_s)
    );

    // Next-state and datapath: latch on start, scan one element per cycle, publish in DONE.
    always_comb begin
        state_d             = state_q;
        nums_d              = nums_q;
        act_d               = act_q;
        sign_d              = sign_q;
        mode_d              = mode_q;
        idx_d               = idx_q;
        best_d              = best_q;
        best_idx_d          = best_idx_q;
        found_d             = found_q;
        busy_d              = busy_q;
        done_d              = 1'b0;
        result_d            = result_q;
        result_index_d      = result_index_q;
        result_activation_d = result_activation_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int i = 0; i < NUM_INPUTS; i++) begin
                        nums_d[i] = numbers[i*WIDTH +: WIDTH];
                    end
                    act_d      = activations;
                    sign_d     = signs;
                    mode_d     = mode;
                    idx_d      = {IDX_W{1'b0}};
                    best_d     = {WIDTH{1'b0}};
                    best_idx_d = {IDX_W{1'b0}};
                    found_d    = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = SCAN;
                end else begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end

            SCAN: begin
                if (take_s) begin
                    best_d     = cand_s;
                    best_idx_d = idx_q;
                end else begin
                    best_d     = best_q;
                    best_idx_d = best_idx_q;
                end
                found_d = qual_any_s;
                if (idx_q == LAST_IDX) begin
                    idx_d   = {IDX_W{1'b0}};
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1'b1);
                    busy_d  = 1'b1;
                    state_d = SCAN;
                end
            end

            DONE: begin
                done_d              = 1'b1;
                busy_d              = 1'b0;
                result_activation_d = found_q;
                if (found_q) begin
                    result_d       = best_q;
                    result_index_d = best_idx_q;
                end else begin
                    result_d       = {WIDTH{1'b0}};
                    result_index_d = {IDX_W{1'b0}};
                end
                state_d = IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; synchronous active-low reset abandons any scan.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                nums_q[i] <= {WIDTH{1'b0}};
            end
            act_q               <= {NUM_INPUTS{1'b0}};
            sign_q              <= {NUM_INPUTS{1'b0}};
            mode_q              <= 1'b0;
            idx_q               <= {IDX_W{1'b0}};
            best_q              <= {WIDTH{1'b0}};
            best_idx_q          <= {IDX_W{1'b0}};
            found_q             <= 1'b0;
            busy_q              <= 1'b0;
            done_q              <= 1'b0;
            result_q            <= {WIDTH{1'b0}};
            result_index_q      <= {IDX_W{1'b0}};
            result_activation_q <= 1'b0;
        end else begin
            state_q             <= state_d;
            nums_q              <= nums_d;
            act_q               <= act_d;
            sign_q              <= sign_d;
            mode_q              <= mode_d;
            idx_q               <= idx_d;
            best_q              <= best_d;
            best_idx_q          <= best_idx_d;
            found_q             <= found_d;
            busy_q              <= busy_d;
            done_q              <= done_d;
            result_q            <= result_d;
            result_index_q      <= result_index_d;
            result_activation_q <= result_activation_d;
        end
    end

    assign busy              = busy_q;
    assign done              = done_q;
    assign result            = result_q;
    assign result_index      = result_index_q;
    assign result_activation = result_activation_q;

endmodule

// File: tb/tb_minmax_scan_reducer.sv
// Self-checking bench for minmax_scan_reducer: directed table, reset and
// start-held sequences, plus randomized vectors against a reference model.
module tb_minmax_scan_reducer;

    localparam int W = 8;
    localparam int N = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic               mode;
    logic [N*W-1:0]     numbers;
    logic [N-1:0]       activations;
    logic [N-1:0]       signs;
    logic               busy;
    logic               done;
    logic signed [W-1:0] result;
    logic [2:0]         result_index;
    logic               result_activation;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [N*W-1:0] nums;
        logic [N-1:0]   act;
        logic [N-1:0]   sgn;
        logic           md;
        int             er;
        int             ei;
        int             ea;
    } vec_t;

    minmax_scan_reducer #(.WIDTH(W), .NUM_INPUTS(N)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .mode              (mode),
        .numbers           (numbers),
        .activations       (activations),
        .signs             (signs),
        .busy              (busy),
        .done              (done),
        .result            (result),
        .result_index      (result_index),
        .result_activation (result_activation)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic logic [N*W-1:0] pack8(input int a0, input int a1, input int a2, input int a3,
                                             input int a4, input int a5, input int a6, input int a7);
        return {a7[7:0], a6[7:0], a5[7:0], a4[7:0], a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
    endfunction

    function automatic int elem(input logic [N*W-1:0] nums, input int k);
        logic signed [W-1:0] e;
        e = nums[k*W +: W];
        return int'(e);
    endfunction

    // Reference: gather qualifying indices, pick extreme value, earliest index wins ties.
    function automatic void ref_model(inout vec_t v);
        int q[$];
        int bi;
        for (int i = 0; i < N; i++) begin
            if (v.act[i] && !v.sgn[i]) q.push_back(i);
        end
        if (q.size() == 0) begin
            v.er = 0; v.ei = 0; v.ea = 0;
        end else begin
            bi = q[0];
            for (int j = 1; j < q.size(); j++) begin
                if (v.md == 1'b0 ? (elem(v.nums, q[j]) > elem(v.nums, bi))
                                 : (elem(v.nums, q[j]) < elem(v.nums, bi)))
                    bi = q[j];
            end
            v.er = elem(v.nums, bi); v.ei = bi; v.ea = 1;
        end
    endfunction

    task automatic scramble_inputs();
        numbers     = {$urandom, $urandom};
        activations = N'($urandom);
        signs       = N'($urandom);
        mode        = 1'($urandom);
    endtask

    task automatic check_result(input string tag, input vec_t v);
        check({tag, "_res"}, int'(result), v.er);
        check({tag, "_idx"}, int'(result_index), v.ei);
        check({tag, "_act"}, int'(result_activation), v.ea);
    endtask

    // Wait (bounded) for done after the current edge; returns edges counted.
    task automatic wait_done(input bit randomize_inputs, output int cyc);
        cyc = 0;
        while (!done && cyc < 50) begin
            if (randomize_inputs) begin
                @(negedge clk);
                scramble_inputs();
            end
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic run_one(input vec_t v, input string tag);
        int cyc;
        @(negedge clk);
        numbers = v.nums; activations = v.act; signs = v.sgn; mode = v.md; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy"}, int'(busy), 1);
        scramble_inputs();
        wait_done(1'b0, cyc);
        check({tag, "_latency"}, cyc, N + 1);
        check({tag, "_busy_at_done"}, int'(busy), 0);
        check_result(tag, v);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, int'(done), 0);
        check({tag, "_hold"}, int'(result), v.er);
    endtask

    initial begin
        vec_t tbl[6];
        vec_t v;
        vec_t a;
        vec_t b;
        int   cyc;
        bit   seen;

        tbl[0] = '{pack8(3, -5, 17, 0, 17, -128, 127, 2), 8'hFF, 8'h00, 1'b0, 127, 6, 1};
        tbl[1] = '{pack8(-128, 4, -7, 9, 10, 20, 30, 40), 8'hFE, 8'h04, 1'b1, 4, 1, 1};
        tbl[2] = '{pack8(5, 9, 9, 1, 0, -1, 2, 3), 8'hFF, 8'h00, 1'b0, 9, 1, 1};
        tbl[3] = '{pack8(5, 9, 9, 1, 0, -1, 2, 3), 8'h00, 8'h00, 1'b0, 0, 0, 0};
        tbl[4] = '{pack8(-3, 7, -3, -3, 0, 1, 2, 3), 8'hFF, 8'h00, 1'b1, -3, 0, 1};
        tbl[5] = '{pack8(100, 50, -20, 0, 9, 8, 7, -1), 8'h80, 8'h00, 1'b0, -1, 7, 1};

        rst_n = 1'b0; start = 1'b0; mode = 1'b0;
        numbers = '0; activations = '0; signs = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_res", int'(result), 0);
        check("rst_idx", int'(result_index), 0);
        check("rst_act", int'(result_activation), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_one(tbl[i], $sformatf("tbl%0d", i));
        end

        // Reset in the middle of a scan: abandoned, no done, fresh scan afterwards.
        run_one(tbl[0], "pre_rst");
        @(negedge clk);
        numbers = tbl[1].nums; activations = tbl[1].act; signs = tbl[1].sgn; mode = tbl[1].md;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_res", int'(result), 0);
        check("midrst_idx", int'(result_index), 0);
        check("midrst_act", int'(result_activation), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < N + 4; i++) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        check("midrst_no_done", int'(seen), 0);
        run_one(tbl[1], "post_rst");

        // Start held high with inputs churning: only latched vectors matter.
        a.nums = {$urandom, $urandom}; a.act = 8'hFF; a.sgn = 8'h00; a.md = 1'b0;
        ref_model(a);
        b.nums = {$urandom, $urandom}; b.act = 8'h5A; b.sgn = 8'h10; b.md = 1'b1;
        ref_model(b);
        @(negedge clk);
        numbers = a.nums; activations = a.act; signs = a.sgn; mode = a.md; start = 1'b1;
        @(posedge clk); #1;
        wait_done(1'b1, cyc);
        check("held_a_latency", cyc, N + 1);
        check_result("held_a", a);
        @(negedge clk);
        numbers = b.nums; activations = b.act; signs = b.sgn; mode = b.md;
        @(posedge clk); #1;
        check("held_b_busy", int'(busy), 1);
        wait_done(1'b1, cyc);
        check("held_spacing", cyc + 1, N + 2);
        check_result("held_b", b);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);

        // Randomized vectors; small value ranges on some runs to force ties.
        for (int r = 0; r < 30; r++) begin
            v.nums = {$urandom, $urandom};
            if (r % 3 == 0) begin
                for (int k = 0; k < N; k++) v.nums[k*W +: W] = W'($urandom_range(0, 3));
            end
            v.act = N'($urandom);
            v.sgn = N'($urandom & $urandom);
            v.md  = 1'($urandom_range(0, 1));
            ref_model(v);
            run_one(v, $sformatf("rnd%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
